// File: rtl/acc_pkg.sv
// Shared types for the accumulator SRAM sequencer: FSM encoding and the
// S1 read-modify-write pipeline register.
package acc_pkg;

   localparam int ACC_DEPTH = 1024;
   localparam int ACC_AW    = $clog2(ACC_DEPTH);
   localparam int ACC_DW    = 32;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_WAIT  = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   typedef struct packed {
      logic              valid;
      logic [ACC_AW-1:0] addr;
      logic [ACC_DW-1:0] data;
      logic              first;
      logic              fwd_hit;
   } s1_t;

endpackage

// File: rtl/acc_out_fifo.sv
// 2-entry fall-through valid/ready FIFO; zero latency when empty.
// pop_rdy low holds data in place; the caller must not push while count == 2.
module acc_out_fifo #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   output logic         pop_vld,
   input  logic         pop_rdy,
   output logic [W-1:0] pop_dat,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   cnt;
   logic         has_data;
   logic         bypass;
   logic         store;
   logic         deq;

   assign count    = cnt;
   assign has_data = (cnt != 2'd0);
   assign pop_vld  = has_data | push_vld;
   assign pop_dat  = has_data ? mem[rd_ptr] : (push_vld ? push_dat : '0);

   // An empty FIFO hands the incoming word straight through when it is taken.
   assign bypass = ~has_data & push_vld & pop_rdy;
   assign store  = push_vld & ~bypass;
   assign deq    = has_data & pop_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (store) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (deq) begin
            rd_ptr <= ~rd_ptr;
         end
         cnt <= cnt + {1'b0, store} - {1'b0, deq};
      end
   end

endmodule

// File: rtl/acc_sram_ctrl.sv
// Read-modify-write sequencer for the accumulator SRAM: 1 beat/cycle accumulate
// with S1->S0 forwarding, plus a credit-limited drain to a valid/ready stream.
module acc_sram_ctrl
   import acc_pkg::*;
#(
   parameter  int SRAM_DEPTH = ACC_DEPTH,
   parameter  int DATA_WIDTH = ACC_DW,
   localparam int AW         = $clog2(SRAM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  acc_valid,
   output logic                  acc_ready,
   input  logic [AW-1:0]         acc_addr,
   input  logic [DATA_WIDTH-1:0] acc_data,
   input  logic                  acc_first,
   input  logic                  drain_start,
   input  logic [AW-1:0]         drain_base,
   input  logic [AW:0]           drain_len,
   input  logic                  drain_clear,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  ram_wea,
   output logic [AW-1:0]         ram_addra,
   output logic [DATA_WIDTH-1:0] ram_dia,
   output logic                  ram_enb,
   output logic [AW-1:0]         ram_addrb,
   input  logic [DATA_WIDTH-1:0] ram_dob
);

   state_t                state;
   s1_t                   s1;
   logic [DATA_WIDTH-1:0] s1_prev_sum;
   logic [DATA_WIDTH-1:0] s1_operand;
   logic [DATA_WIDTH-1:0] s1_sum;
   logic [AW-1:0]         rd_addr;
   logic [AW:0]           rd_left;
   logic                  clear_q;
   logic                  inflight;
   logic                  inflight_last;
   logic [1:0]            fifo_count;
   logic [DATA_WIDTH:0]   fifo_dat;
   logic                  acc_fire;
   logic                  s1_wr;
   logic                  rd_issue;
   logic                  clr_wr;
   logic                  last_pop;

   assign acc_ready = ~rst & (state == ST_IDLE) & ~drain_start;
   assign acc_fire  = acc_valid & acc_ready;
   assign s1_wr     = s1.valid & ~rst;

   // Credit rule: stored words plus the read in flight never exceed the FIFO depth.
   assign rd_issue = ~rst & (state == ST_DRAIN) & (rd_left != '0) &
                     ((fifo_count == 2'd0) | ((fifo_count == 2'd1) & ~inflight));
   assign clr_wr   = rd_issue & clear_q;

   always_comb begin
      s1_operand = ram_dob;
      if (s1.first) begin
         s1_operand = '0;
      end else if (s1.fwd_hit) begin
         s1_operand = s1_prev_sum;
      end
   end

   assign s1_sum = s1_operand + s1.data;

   assign ram_wea   = s1_wr | clr_wr;
   assign ram_addra = s1_wr ? s1.addr : (clr_wr ? rd_addr : '0);
   assign ram_dia   = s1_wr ? s1_sum : '0;
   assign ram_enb   = acc_fire | rd_issue;
   assign ram_addrb = rd_issue ? rd_addr : (acc_fire ? acc_addr : '0);

   assign busy     = (state != ST_IDLE) | s1.valid;
   assign out_last = fifo_dat[DATA_WIDTH];
   assign out_data = fifo_dat[DATA_WIDTH-1:0];
   assign last_pop = out_valid & out_ready & out_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1          <= '0;
         s1_prev_sum <= '0;
      end else begin
         s1.valid <= acc_fire;
         if (acc_fire) begin
            s1.addr    <= acc_addr;
            s1.data    <= acc_data;
            s1.first   <= acc_first;
            s1.fwd_hit <= s1.valid & (s1.addr == acc_addr);
         end
         if (s1.valid) begin
            s1_prev_sum <= s1_sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         rd_addr       <= '0;
         rd_left       <= '0;
         clear_q       <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= rd_issue;
         inflight_last <= rd_issue & (rd_left == (AW+1)'(1));
         case (state)
            ST_IDLE: begin
               if (drain_start) begin
                  rd_addr <= drain_base;
                  rd_left <= (drain_len == '0) ? (AW+1)'(1) : drain_len;
                  clear_q <= drain_clear;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!s1.valid) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (rd_issue) begin
                  rd_addr <= (rd_addr == AW'(SRAM_DEPTH-1)) ? '0 : rd_addr + 1'b1;
                  rd_left <= rd_left - 1'b1;
               end
               if (last_pop) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   acc_out_fifo #(
      .W (DATA_WIDTH + 1)
   ) u_out_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (inflight & ~rst),
      .push_dat ({inflight_last, ram_dob}),
      .pop_vld  (out_valid),
      .pop_rdy  (out_ready),
      .pop_dat  (fifo_dat),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_acc_sram_ctrl.sv
// Directed bench for acc_sram_ctrl with a behavioural read-first SRAM model.
module tb_acc_sram_ctrl;

   logic        clk;
   logic        rst;
   logic        acc_valid;
   logic        acc_ready;
   logic [9:0]  acc_addr;
   logic [31:0] acc_data;
   logic        acc_first;
   logic        drain_start;
   logic [9:0]  drain_base;
   logic [10:0] drain_len;
   logic        drain_clear;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        ram_wea;
   logic [9:0]  ram_addra;
   logic [31:0] ram_dia;
   logic        ram_enb;
   logic [9:0]  ram_addrb;
   logic [31:0] ram_dob;

   logic [31:0] mem [1024];
   logic [31:0] exp_q [$];
   int          n_tests;
   int          n_fail;

   acc_sram_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .acc_valid   (acc_valid),
      .acc_ready   (acc_ready),
      .acc_addr    (acc_addr),
      .acc_data    (acc_data),
      .acc_first   (acc_first),
      .drain_start (drain_start),
      .drain_base  (drain_base),
      .drain_len   (drain_len),
      .drain_clear (drain_clear),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .ram_wea     (ram_wea),
      .ram_addra   (ram_addra),
      .ram_dia     (ram_dia),
      .ram_enb     (ram_enb),
      .ram_addrb   (ram_addrb),
      .ram_dob     (ram_dob)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first simple dual-port SRAM, 1-cycle registered read.
   always @(posedge clk) begin
      if (ram_enb) ram_dob <= mem[ram_addrb];
      if (ram_wea) mem[ram_addra] <= ram_dia;
   end

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] d [4];
      int          nb;
      int          gap;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic acc_beat(input logic [9:0] a, input logic [31:0] d, input logic f);
      @(negedge clk);
      acc_valid = 1'b1;
      acc_addr  = a;
      acc_data  = d;
      acc_first = f;
      #1;
      chk("acc_ready_on_beat", acc_ready, 1);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      acc_valid = 1'b0;
   endtask

   // Drains len words from base and compares against exp_q. Cycle 0 is the drain_start cycle.
   task automatic do_drain(input logic [9:0] base, input logic [10:0] len, input logic clr,
                           input bit rnd, input bit with_beat);
      int n, idx, issued, popped, last_c, len_eff;
      int ar_bad, credit_bad, clr_bad, hold_bad;
      bit done, held;
      logic [31:0] held_dat;
      n = exp_q.size();
      idx = 0; issued = 0; popped = 0; last_c = 0;
      ar_bad = 0; credit_bad = 0; clr_bad = 0; hold_bad = 0;
      done = 0; held = 0; held_dat = '0;
      len_eff = (len == 0) ? 1 : int'(len);
      @(negedge clk);
      acc_valid   = with_beat;
      acc_addr    = base;
      acc_data    = 32'd100;
      acc_first   = 1'b0;
      drain_start = 1'b1;
      drain_base  = base;
      drain_len   = len;
      drain_clear = clr;
      out_ready   = 1'b0;
      #1;
      chk("acc_ready_at_drain_start", acc_ready, 0);
      for (int c = 1; c < 200 && !done; c++) begin
         @(negedge clk);
         drain_start = 1'b0;
         acc_valid   = 1'b0;
         out_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (acc_ready) ar_bad++;
         if (held && (!out_valid || out_data !== held_dat)) hold_bad++;
         if (ram_enb) begin
            if (issued - popped >= 2) credit_bad++;
            issued++;
            if (clr && !(ram_wea && ram_addra == ram_addrb && ram_dia == 32'd0)) clr_bad++;
         end
         held = out_valid && !out_ready;
         held_dat = out_data;
         if (out_valid && out_ready) begin
            if (idx < n) begin
               chk("drain_data", out_data, exp_q[idx]);
               chk("drain_last", out_last, (idx == n - 1));
            end
            popped++;
            idx++;
            if (out_last) begin
               done   = 1;
               last_c = c;
            end
         end
      end
      chk("drain_completed", done, 1);
      chk("drain_word_count", idx, n);
      if (!rnd) chk("drain_last_cycle", last_c, 2 + len_eff);
      chk("acc_ready_low_while_busy", ar_bad, 0);
      chk("read_credit", credit_bad, 0);
      chk("out_hold_stable", hold_bad, 0);
      if (clr) chk("clear_write", clr_bad, 0);
      @(negedge clk);
      #1;
      chk("busy_after_drain", busy, 0);
      chk("acc_ready_after_drain", acc_ready, 1);
      exp_q.delete();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      acc_valid = 0; acc_addr = '0; acc_data = '0; acc_first = 0;
      drain_start = 0; drain_base = '0; drain_len = '0; drain_clear = 0;
      out_ready = 0;

      vecs[0] = '{addr: 10'd3,    d: '{32'd5, 32'd7, 0, 0},                   nb: 2, gap: 2, exp: 32'd12};
      vecs[1] = '{addr: 10'd10,   d: '{32'd1, 32'd2, 32'd3, 32'd4},           nb: 4, gap: 0, exp: 32'd10};
      vecs[2] = '{addr: 10'd0,    d: '{32'hFFFF_FFFF, 32'd2, 0, 0},           nb: 2, gap: 1, exp: 32'd1};
      vecs[3] = '{addr: 10'd1023, d: '{32'd100, 0, 0, 0},                     nb: 1, gap: 0, exp: 32'd100};
      vecs[4] = '{addr: 10'd500,  d: '{32'h8000_0000, 32'h8000_0000, 32'd1, 0}, nb: 3, gap: 0, exp: 32'd1};
      vecs[5] = '{addr: 10'd11,   d: '{32'd10, 32'hFFFF_FFFF, 0, 0},          nb: 2, gap: 0, exp: 32'd9};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_acc_ready", acc_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_last", out_last, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ram_wea", ram_wea, 0);
      chk("reset_ram_enb", ram_enb, 0);
      chk("reset_ram_addra", ram_addra, 0);
      chk("reset_ram_dia", ram_dia, 0);
      chk("reset_ram_addrb", ram_addrb, 0);

      for (int v = 0; v < 6; v++) begin
         for (int b = 0; b < vecs[v].nb; b++) begin
            acc_beat(vecs[v].addr, vecs[v].d[b], (b == 0));
            if (b != vecs[v].nb - 1) repeat (vecs[v].gap) idle_cycle();
         end
         exp_q.push_back(vecs[v].exp);
         do_drain(vecs[v].addr, 11'd1, 1'b0, 0, 0);
      end

      // len 0 behaves as a single-word drain
      exp_q.push_back(32'd12);
      do_drain(10'd3, 11'd0, 1'b0, 0, 0);

      // Beat presented with drain_start must be refused: word stays 12
      exp_q.push_back(32'd12);
      do_drain(10'd3, 11'd1, 1'b0, 0, 1);

      // Interleaved addresses: forwarding must only fire on an address match
      acc_beat(10'd30, 32'd5, 1'b1);
      acc_beat(10'd31, 32'd9, 1'b1);
      acc_beat(10'd30, 32'd1, 1'b0);
      acc_beat(10'd31, 32'd2, 1'b0);
      exp_q.push_back(32'd6);
      exp_q.push_back(32'd11);
      do_drain(10'd30, 11'd2, 1'b0, 0, 0);

      // Wrap-around drain with clear, then a repeat drain sees zeros
      acc_beat(10'd1022, 32'hA1, 1'b1);
      acc_beat(10'd1023, 32'hB2, 1'b1);
      acc_beat(10'd0,    32'hC3, 1'b1);
      acc_beat(10'd1,    32'hD4, 1'b1);
      exp_q.push_back(32'hA1);
      exp_q.push_back(32'hB2);
      exp_q.push_back(32'hC3);
      exp_q.push_back(32'hD4);
      do_drain(10'd1022, 11'd4, 1'b1, 0, 0);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
      do_drain(10'd1022, 11'd4, 1'b1, 0, 0);

      // Backpressure with random out_ready
      for (int i = 0; i < 8; i++) acc_beat(10'(20 + i), 32'h100 + 32'(i), 1'b1);
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(i));
      do_drain(10'd20, 11'd8, 1'b0, 1, 0);

      // Reset in the middle of a stalled drain
      @(negedge clk);
      acc_valid   = 1'b0;
      drain_start = 1'b1;
      drain_base  = 10'd20;
      drain_len   = 11'd8;
      drain_clear = 1'b0;
      out_ready   = 1'b0;
      @(negedge clk);
      drain_start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("stalled_out_valid", out_valid, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_acc_ready", acc_ready, 1);
      chk("midrst_ram_wea", ram_wea, 0);
      chk("midrst_ram_enb", ram_enb, 0);
      exp_q.push_back(32'h100);
      do_drain(10'd20, 11'd1, 1'b0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
